// File: rtl/execute_stage_pkg.sv
// Shared widths, RV32I opcode/funct3 encodings and the EX/MEM register layout
// used by the Execute stage and its ALU.
package execute_stage_pkg;

    localparam int N          = 32;
    localparam int ADDR_WIDTH = 32;

    // Major opcodes (instr[6:0]) recognised by Execute.
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    // ALU funct3 encodings.
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    // Branch funct3 encodings; 010 and 011 are reserved.
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Payload half of the EX/MEM pipeline register (valid lives separately).
    typedef struct packed {
        logic [N-1:0]          result;
        logic [N-1:0]          data_store;
        logic [ADDR_WIDTH-1:0] pc;
        logic [2:0]            func3;
        logic [4:0]            rd;
        logic [6:0]            opcode;
        logic                  illegal;
    } ex_mem_t;

    // Jump targets must be halfword aligned: bit 0 is dropped.
    function automatic logic [ADDR_WIDTH-1:0] align_target(input logic [ADDR_WIDTH-1:0] addr);
        return {addr[ADDR_WIDTH-1:1], 1'b0};
    endfunction

endpackage

// File: rtl/execute_stage_alu.sv
// Purely combinational RV32I integer ALU for OP and OP-IMM instructions.
// Operand B selection is done by the caller; is_op only gates SUB.
module execute_stage_alu
    import execute_stage_pkg::*;
(
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic [2:0]   i_func3,
    input  logic         i_func7_b5,
    input  logic         i_is_op,
    output logic [N-1:0] o_result
);

    logic [4:0]   w_shamt;
    logic [N-1:0] w_sra;
    logic         w_lt_signed;
    logic         w_lt_unsigned;

    assign w_shamt       = i_b[4:0];
    // Kept in its own net so the arithmetic shift is never coerced to unsigned.
    assign w_sra         = $signed(i_a) >>> w_shamt;
    assign w_lt_signed   = $signed(i_a) < $signed(i_b);
    assign w_lt_unsigned = i_a < i_b;

    // NOTE: o_result gets a default before the case so no path can infer a latch.
    always_comb begin
        o_result = '0;
        case (i_func3)
            F3_ADD_SUB: o_result = (i_is_op && i_func7_b5) ? i_a - i_b : i_a + i_b;
            F3_SLL:     o_result = i_a << w_shamt;
            F3_SLT:     o_result = {{(N-1){1'b0}}, w_lt_signed};
            F3_SLTU:    o_result = {{(N-1){1'b0}}, w_lt_unsigned};
            F3_XOR:     o_result = i_a ^ i_b;
            F3_SRL_SRA: o_result = i_func7_b5 ? w_sra : (i_a >> w_shamt);
            F3_OR:      o_result = i_a | i_b;
            F3_AND:     o_result = i_a & i_b;
            default:    o_result = '0;
        endcase
    end

endmodule

// File: rtl/execute_stage.sv
// RV32I Execute stage: ALU, address/link/target generation, branch resolution,
// EX/MEM pipeline register with Memory stall, and one-cycle redirect to Fetch/Decode.
module execute_stage
    import execute_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_id_valid,
    input  logic [ADDR_WIDTH-1:0] i_pc,
    input  logic [N-1:0]          i_rs1_data,
    input  logic [N-1:0]          i_rs2_data,
    input  logic [N-1:0]          i_imm,
    input  logic [2:0]            i_func3,
    input  logic                  i_func7_b5,
    input  logic [4:0]            i_rd,
    input  logic [6:0]            i_opcode,
    output logic                  o_ex_stall,
    input  logic                  i_mem_stall,
    output logic [N-1:0]          o_result,
    output logic [N-1:0]          o_data_store,
    output logic [ADDR_WIDTH-1:0] o_pc,
    output logic [2:0]            o_func3,
    output logic [4:0]            o_rd,
    output logic [6:0]            o_opcode,
    output logic                  o_ex_valid,
    output logic                  o_redirect,
    output logic [ADDR_WIDTH-1:0] o_redirect_pc,
    output logic                  o_illegal
);

    ex_mem_t               r_ex_mem;
    logic                  r_ex_valid;
    logic                  r_redirect;
    logic                  r_squash;
    logic [ADDR_WIDTH-1:0] r_redirect_pc;

    ex_mem_t               w_ex_mem_d;
    logic                  w_ce;
    logic                  w_valid_in;
    logic                  w_is_op;
    logic                  w_taken;
    logic                  w_branch_illegal;
    logic                  w_redirect;
    logic                  w_fire;
    logic [N-1:0]          w_opb;
    logic [N-1:0]          w_alu_result;
    logic [N-1:0]          w_addr_sum;
    logic [ADDR_WIDTH-1:0] w_pc_imm;
    logic [ADDR_WIDTH-1:0] w_pc_plus4;
    logic [ADDR_WIDTH-1:0] w_target;

    assign w_ce       = ~i_mem_stall;
    assign o_ex_stall = i_mem_stall;

    // The instruction right behind a redirect is wrong-path and enters as a bubble.
    assign w_valid_in = i_id_valid & ~r_squash;

    assign w_is_op    = (i_opcode == OP);
    assign w_opb      = w_is_op ? i_rs2_data : i_imm;
    assign w_addr_sum = i_rs1_data + i_imm;
    assign w_pc_imm   = i_pc + i_imm;
    assign w_pc_plus4 = i_pc + ADDR_WIDTH'(4);

    execute_stage_alu u_alu (
        .i_a        (i_rs1_data),
        .i_b        (w_opb),
        .i_func3    (i_func3),
        .i_func7_b5 (i_func7_b5),
        .i_is_op    (w_is_op),
        .o_result   (w_alu_result)
    );

    // Branch comparator always compares rs1 against rs2, never the immediate.
    always_comb begin
        w_taken          = 1'b0;
        w_branch_illegal = 1'b0;
        case (i_func3)
            F3_BEQ:  w_taken = (i_rs1_data == i_rs2_data);
            F3_BNE:  w_taken = (i_rs1_data != i_rs2_data);
            F3_BLT:  w_taken = ($signed(i_rs1_data) <  $signed(i_rs2_data));
            F3_BGE:  w_taken = ($signed(i_rs1_data) >= $signed(i_rs2_data));
            F3_BLTU: w_taken = (i_rs1_data <  i_rs2_data);
            F3_BGEU: w_taken = (i_rs1_data >= i_rs2_data);
            default: w_branch_illegal = 1'b1;
        endcase
    end

    always_comb begin
        w_ex_mem_d            = '0;
        w_ex_mem_d.data_store = i_rs2_data;
        w_ex_mem_d.pc         = i_pc;
        w_ex_mem_d.func3      = i_func3;
        w_ex_mem_d.rd         = i_rd;
        w_ex_mem_d.opcode     = i_opcode;
        w_redirect            = 1'b0;
        w_target              = w_pc_imm;
        case (i_opcode)
            OP, OP_IMM:  w_ex_mem_d.result = w_alu_result;
            LOAD, STORE: w_ex_mem_d.result = w_addr_sum;
            JAL: begin
                w_ex_mem_d.result = w_pc_plus4;
                w_redirect        = 1'b1;
            end
            JALR: begin
                w_ex_mem_d.result = w_pc_plus4;
                w_redirect        = 1'b1;
                w_target          = align_target(w_addr_sum);
            end
            LUI:   w_ex_mem_d.result = i_imm;
            AUIPC: w_ex_mem_d.result = w_pc_imm;
            BRANCH: begin
                w_ex_mem_d.illegal = w_branch_illegal;
                w_redirect         = w_taken;
            end
            default: w_ex_mem_d.illegal = 1'b1;
        endcase
    end

    assign w_fire = w_valid_in & w_redirect;

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    // The redirect pulse drops after one cycle even while the stall holds everything else.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_mem      <= '0;
            r_ex_valid    <= 1'b0;
            r_redirect    <= 1'b0;
            r_squash      <= 1'b0;
            r_redirect_pc <= '0;
        end else if (w_ce) begin
            r_ex_mem   <= w_ex_mem_d;
            r_ex_valid <= w_valid_in;
            r_redirect <= w_fire;
            r_squash   <= w_fire;
            if (w_fire) begin
                r_redirect_pc <= w_target;
            end
        end else begin
            r_redirect <= 1'b0;
        end
    end

    assign o_result      = r_ex_mem.result;
    assign o_data_store  = r_ex_mem.data_store;
    assign o_pc          = r_ex_mem.pc;
    assign o_func3       = r_ex_mem.func3;
    assign o_rd          = r_ex_mem.rd;
    assign o_opcode      = r_ex_mem.opcode;
    assign o_illegal     = r_ex_mem.illegal;
    assign o_ex_valid    = r_ex_valid;
    assign o_redirect    = r_redirect;
    assign o_redirect_pc = r_redirect_pc;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed vector table, hand-written
// redirect/stall/reset sequences, and randomized traffic against a reference model.
module tb_execute_stage;

    localparam logic [6:0] C_OP     = 7'b0110011;
    localparam logic [6:0] C_OP_IMM = 7'b0010011;
    localparam logic [6:0] C_LOAD   = 7'b0000011;
    localparam logic [6:0] C_STORE  = 7'b0100011;
    localparam logic [6:0] C_BRANCH = 7'b1100011;
    localparam logic [6:0] C_JAL    = 7'b1101111;
    localparam logic [6:0] C_JALR   = 7'b1100111;
    localparam logic [6:0] C_LUI    = 7'b0110111;
    localparam logic [6:0] C_AUIPC  = 7'b0010111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, func7_b5, mem_stall;
    logic [31:0] pc, rs1, rs2, imm;
    logic [2:0]  func3;
    logic [4:0]  rd;
    logic [6:0]  opcode;
    logic        ex_stall, ex_valid, redirect, illegal;
    logic [31:0] result, data_store, o_pc_w, redirect_pc;
    logic [2:0]  o_func3_w;
    logic [4:0]  o_rd_w;
    logic [6:0]  o_opcode_w;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    execute_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_id_valid    (id_valid),
        .i_pc          (pc),
        .i_rs1_data    (rs1),
        .i_rs2_data    (rs2),
        .i_imm         (imm),
        .i_func3       (func3),
        .i_func7_b5    (func7_b5),
        .i_rd          (rd),
        .i_opcode      (opcode),
        .o_ex_stall    (ex_stall),
        .i_mem_stall   (mem_stall),
        .o_result      (result),
        .o_data_store  (data_store),
        .o_pc          (o_pc_w),
        .o_func3       (o_func3_w),
        .o_rd          (o_rd_w),
        .o_opcode      (o_opcode_w),
        .o_ex_valid    (ex_valid),
        .o_redirect    (redirect),
        .o_redirect_pc (redirect_pc),
        .o_illegal     (illegal)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                         input logic [31:0] pc_v, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] im, input logic [4:0] rd_v);
        id_valid = v; opcode = opc; func3 = f3; func7_b5 = f7;
        pc = pc_v; rs1 = a; rs2 = b; imm = im; rd = rd_v;
    endtask

    // Reference model: what a single instruction produces, straight from the ISA rules.
    typedef struct packed {
        logic [31:0] result;
        logic        illegal;
        logic        redir;
        logic [31:0] target;
    } mres_t;

    function automatic mres_t model(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                                    input logic [31:0] pc_v, input logic [31:0] a,
                                    input logic [31:0] b2, input logic [31:0] im);
        mres_t m;
        logic [31:0] b, alu;
        int sh, sa, sb, s1, s2;
        logic taken;
        m = '0;
        b = (opc == C_OP) ? b2 : im;
        sh = int'(b[4:0]);
        sa = a; sb = b; s1 = a; s2 = b2;
        case (f3)
            3'd0: alu = (opc == C_OP && f7) ? a - b : a + b;
            3'd1: alu = a << sh;
            3'd2: alu = (sa < sb) ? 32'd1 : 32'd0;
            3'd3: alu = (a < b) ? 32'd1 : 32'd0;
            3'd4: alu = a ^ b;
            3'd5: begin
                alu = a >> sh;
                if (f7 && a[31]) alu = alu | ~(32'hFFFF_FFFF >> sh);
            end
            3'd6: alu = a | b;
            default: alu = a & b;
        endcase
        case (f3)
            3'd0: taken = (a == b2);
            3'd1: taken = (a != b2);
            3'd4: taken = (s1 < s2);
            3'd5: taken = (s1 >= s2);
            3'd6: taken = (a < b2);
            3'd7: taken = (a >= b2);
            default: taken = 1'b0;
        endcase
        case (opc)
            C_OP, C_OP_IMM: m.result = alu;
            C_LOAD, C_STORE: m.result = a + im;
            C_JAL: begin
                m.result = pc_v + 32'd4; m.redir = 1'b1; m.target = pc_v + im;
            end
            C_JALR: begin
                m.result = pc_v + 32'd4; m.redir = 1'b1; m.target = (a + im) & 32'hFFFF_FFFE;
            end
            C_LUI:   m.result = im;
            C_AUIPC: m.result = pc_v + im;
            C_BRANCH: begin
                m.illegal = (f3 == 3'd2) || (f3 == 3'd3);
                m.redir   = taken;
                m.target  = pc_v + im;
            end
            default: m.illegal = 1'b1;
        endcase
        return m;
    endfunction

    typedef struct {
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        f7;
        logic [31:0] pc, rs1, rs2, imm;
        logic [31:0] e_res;
        logic        e_redir;
        logic [31:0] e_rpc;
        logic        e_ill;
    } vec_t;

    vec_t vecs[$];

    // Expected EX/MEM contents for the random phase.
    logic        e_valid, e_redir, e_ill, m_squash;
    logic [31:0] e_res, e_store, e_pc, e_rpc;
    logic [2:0]  e_f3;
    logic [4:0]  e_rd;
    logic [6:0]  e_opc;

    task automatic compare_all(input string tag);
        check({tag, "_result"}, result, e_res);
        check({tag, "_store"}, data_store, e_store);
        check({tag, "_pc"}, o_pc_w, e_pc);
        check({tag, "_ctl"}, {17'b0, o_func3_w, o_rd_w, o_opcode_w}, {17'b0, e_f3, e_rd, e_opc});
        check({tag, "_flags"}, {29'b0, ex_valid, redirect, illegal}, {29'b0, e_valid, e_redir, e_ill});
        check({tag, "_rpc"}, redirect_pc, e_rpc);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_result"}, result, 32'd0);
        check({tag, "_pc"}, o_pc_w, 32'd0);
        check({tag, "_rpc"}, redirect_pc, 32'd0);
        check({tag, "_flags"}, {29'b0, ex_valid, redirect, illegal}, 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
    endtask

    initial begin
        mres_t m;
        logic [6:0] opcs [9];
        opcs = '{C_OP, C_OP_IMM, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_LUI, C_AUIPC};

        rst_n = 1'b0;
        mem_stall = 1'b0;
        drive(1'b0, 7'd0, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0);
        #12;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // opc, f3, f7, pc, rs1, rs2, imm, result, redirect, redirect_pc, illegal
        vecs.push_back('{C_OP,     3'd0, 1'b0, 32'h0,   32'h7FFF_FFFF, 32'h1, 32'h0, 32'h8000_0000, 1'b0, 32'h0, 1'b0});
        vecs.push_back('{C_OP,     3'd0, 1'b1, 32'h0,   32'h0, 32'h1, 32'h0, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0});
        vecs.push_back('{C_OP_IMM, 3'd5, 1'b1, 32'h0,   32'h8000_0000, 32'h0, 32'h4, 32'hF800_0000, 1'b0, 32'h0, 1'b0});
        vecs.push_back('{C_OP,     3'd2, 1'b0, 32'h0,   32'hFFFF_FFFF, 32'h1, 32'h0, 32'h1, 1'b0, 32'h0, 1'b0});
        vecs.push_back('{C_OP,     3'd3, 1'b0, 32'h0,   32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0});
        vecs.push_back('{C_STORE,  3'd2, 1'b0, 32'h0,   32'h1000, 32'hDEAD_BEEF, 32'hFFFF_FFFC, 32'h0FFC, 1'b0, 32'h0, 1'b0});
        vecs.push_back('{C_BRANCH, 3'd0, 1'b0, 32'h100, 32'h5, 32'h5, 32'h20, 32'h0, 1'b1, 32'h120, 1'b0});
        vecs.push_back('{C_JALR,   3'd0, 1'b0, 32'h200, 32'h301, 32'h0, 32'h0, 32'h204, 1'b1, 32'h300, 1'b0});
        vecs.push_back('{C_LUI,    3'd0, 1'b0, 32'h0,   32'h0, 32'h0, 32'h1234_5000, 32'h1234_5000, 1'b0, 32'h0, 1'b0});
        vecs.push_back('{C_AUIPC,  3'd0, 1'b0, 32'h1000, 32'h0, 32'h0, 32'h2000, 32'h3000, 1'b0, 32'h0, 1'b0});
        vecs.push_back('{7'h7F,    3'd0, 1'b0, 32'h0,   32'h9, 32'h9, 32'h9, 32'h0, 1'b0, 32'h0, 1'b1});
        vecs.push_back('{C_BRANCH, 3'd2, 1'b0, 32'h40,  32'h5, 32'h5, 32'h8, 32'h0, 1'b0, 32'h0, 1'b1});
        vecs.push_back('{C_BRANCH, 3'd1, 1'b0, 32'h40,  32'h5, 32'h5, 32'h8, 32'h0, 1'b0, 32'h0, 1'b0});
        vecs.push_back('{C_BRANCH, 3'd6, 1'b0, 32'h40,  32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 32'h0, 1'b1, 32'h30, 1'b0});
        vecs.push_back('{C_BRANCH, 3'd5, 1'b0, 32'h40,  32'hFFFF_FFFF, 32'h1, 32'h8, 32'h0, 1'b0, 32'h0, 1'b0});
        vecs.push_back('{C_JAL,    3'd0, 1'b0, 32'h10,  32'h0, 32'h0, 32'h8, 32'h14, 1'b1, 32'h18, 1'b0});
        vecs.push_back('{C_OP_IMM, 3'd1, 1'b0, 32'h0,   32'h1, 32'h0, 32'd31, 32'h8000_0000, 1'b0, 32'h0, 1'b0});
        vecs.push_back('{C_LOAD,   3'd2, 1'b0, 32'h0,   32'hFFFF_FFFF, 32'h0, 32'h2, 32'h1, 1'b0, 32'h0, 1'b0});

        foreach (vecs[i]) begin
            drive(1'b1, vecs[i].opc, vecs[i].f3, vecs[i].f7, vecs[i].pc,
                  vecs[i].rs1, vecs[i].rs2, vecs[i].imm, 5'(i));
            tick();
            check($sformatf("vec%0d_result", i), result, vecs[i].e_res);
            check($sformatf("vec%0d_store", i), data_store, vecs[i].rs2);
            check($sformatf("vec%0d_ctl", i), {24'b0, o_func3_w, o_rd_w}, {24'b0, vecs[i].f3, 5'(i)});
            check($sformatf("vec%0d_flags", i), {29'b0, ex_valid, redirect, illegal},
                  {29'b0, 1'b1, vecs[i].e_redir, vecs[i].e_ill});
            if (vecs[i].e_redir) check($sformatf("vec%0d_rpc", i), redirect_pc, vecs[i].e_rpc);
            drive(1'b0, C_OP, 3'd0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0);
            tick();
            check($sformatf("vec%0d_pulse_end", i), {30'b0, ex_valid, redirect}, 32'd0);
        end

        // Taken BEQ: wrong-path instruction is a bubble, the next is valid.
        drive(1'b1, C_BRANCH, 3'd0, 1'b0, 32'h100, 32'h5, 32'h5, 32'h20, 5'd0);
        tick();
        check("beq_redirect", {31'b0, redirect}, 32'd1);
        check("beq_target", redirect_pc, 32'h120);
        drive(1'b1, C_OP, 3'd0, 1'b0, 32'h104, 32'h1, 32'h2, 32'h0, 5'd3);
        tick();
        check("beq_squash", {30'b0, ex_valid, redirect}, 32'd0);
        drive(1'b1, C_OP, 3'd0, 1'b0, 32'h120, 32'h1, 32'h2, 32'h0, 5'd3);
        tick();
        check("beq_after", {30'b0, ex_valid, redirect}, 32'd2);
        check("beq_after_result", result, 32'h3);

        // Back-to-back jumps: the second is wrong-path and must not redirect.
        drive(1'b1, C_JAL, 3'd0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h100, 5'd1);
        tick();
        drive(1'b1, C_JAL, 3'd0, 1'b0, 32'h4, 32'h0, 32'h0, 32'h40, 5'd1);
        tick();
        check("b2b_flags", {30'b0, ex_valid, redirect}, 32'd0);
        check("b2b_rpc", redirect_pc, 32'h100);
        drive(1'b1, C_LUI, 3'd0, 1'b0, 32'h100, 32'h0, 32'h0, 32'h7000, 5'd2);
        tick();
        check("b2b_next", {30'b0, ex_valid, redirect}, 32'd2);

        // Redirect followed by a stall: pulse ends, squash waits for the release.
        drive(1'b1, C_JAL, 3'd0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h200, 5'd1);
        tick();
        check("rs_pulse", {31'b0, redirect}, 32'd1);
        mem_stall = 1'b1;
        drive(1'b1, C_OP, 3'd0, 1'b0, 32'h8, 32'h1, 32'h1, 32'h0, 5'd4);
        tick();
        check("rs_pulse_drop", {30'b0, ex_valid, redirect}, 32'd2);
        check("rs_hold_result", result, 32'h4);
        tick();
        mem_stall = 1'b0;
        tick();
        check("rs_squashed", {31'b0, ex_valid}, 32'd0);
        tick();
        check("rs_valid_again", {31'b0, ex_valid}, 32'd1);
        check("rs_result", result, 32'h2);

        // Stall for three cycles with changing inputs: outputs hold.
        drive(1'b1, C_OP, 3'd0, 1'b0, 32'h40, 32'h3, 32'h4, 32'h0, 5'd7);
        tick();
        check("st_first", result, 32'h7);
        mem_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, C_OP, 3'd4, 1'b0, $urandom, $urandom, $urandom, $urandom, 5'(k));
            #1;
            check("st_ex_stall", {31'b0, ex_stall}, 32'd1);
            tick();
            check("st_hold_result", result, 32'h7);
            check("st_hold_pc", o_pc_w, 32'h40);
            check("st_hold_ctl", {24'b0, o_func3_w, o_rd_w}, {24'b0, 3'd0, 5'd7});
        end
        mem_stall = 1'b0;
        drive(1'b1, C_OP, 3'd4, 1'b0, 32'h44, 32'hF0, 32'h0F, 32'h0, 5'd8);
        #1;
        check("st_release_stall", {31'b0, ex_stall}, 32'd0);
        tick();
        check("st_release", result, 32'hFF);
        check("st_release_valid", {31'b0, ex_valid}, 32'd1);

        // Reset while stalled with a pending squash: nothing survives.
        drive(1'b1, C_JAL, 3'd0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h80, 5'd1);
        tick();
        mem_stall = 1'b1;
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        check_zero("rst_mid");
        #1;
        rst_n = 1'b1;
        mem_stall = 1'b0;
        drive(1'b1, C_OP, 3'd0, 1'b0, 32'h0, 32'h5, 32'h6, 32'h0, 5'd9);
        tick();
        check("rst_no_squash", {30'b0, ex_valid, redirect}, 32'd2);
        check("rst_result", result, 32'hB);

        // Randomized traffic against the model.
        @(negedge clk);
        do_reset();
        m_squash = 1'b0; e_valid = 1'b0; e_redir = 1'b0; e_ill = 1'b0;
        e_res = '0; e_store = '0; e_pc = '0; e_rpc = '0; e_f3 = '0; e_rd = '0; e_opc = '0;
        for (int c = 0; c < 400; c++) begin
            logic [6:0]  r_opc;
            logic [31:0] r_rs1, r_rs2;
            r_opc = ($urandom_range(0, 9) == 9) ? 7'($urandom) : opcs[$urandom_range(0, 8)];
            r_rs1 = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 8)) : $urandom;
            r_rs2 = ($urandom_range(0, 3) == 0) ? r_rs1 : $urandom;
            mem_stall = ($urandom_range(0, 4) == 0);
            drive($urandom_range(0, 3) != 0, r_opc, 3'($urandom), 1'($urandom),
                  $urandom & 32'hFFFF_FFFC, r_rs1, r_rs2, $urandom, 5'($urandom));
            #1;
            check("rand_ex_stall", {31'b0, ex_stall}, {31'b0, mem_stall});
            if (!mem_stall) begin
                m       = model(opcode, func3, func7_b5, pc, rs1, rs2, imm);
                e_valid = id_valid & ~m_squash;
                e_redir = e_valid & m.redir;
                e_res   = m.result;
                e_ill   = m.illegal;
                e_store = rs2;
                e_pc    = pc;
                e_f3    = func3;
                e_rd    = rd;
                e_opc   = opcode;
                if (e_redir) e_rpc = m.target;
                m_squash = e_redir;
            end else begin
                e_redir = 1'b0;
            end
            tick();
            compare_all("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
